// File: rtl/ysyx_22050133_ifetch_bus.sv
// Instruction-fetch bridge: takes one PC per handshake, issues an 8-byte-aligned AR/R read,
// and returns the selected 32-bit word plus the raw 64-bit beat. One fetch in flight at a time.
module ysyx_22050133_ifetch_bus #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_valid_i,
    input  logic [31:0] pc_i,
    output logic        pc_ready_o,
    input  logic        flush_i,
    output logic        arvalid_o,
    output logic [31:0] araddr_o,
    input  logic        arready_i,
    input  logic        rvalid_i,
    input  logic [63:0] rdata_i,
    input  logic [1:0]  rresp_i,
    output logic        rready_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_pc_o,
    output logic [31:0] inst_o,
    output logic [63:0] inst64_o,
    output logic        inst_err_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_AR    = 3'd1;
    localparam logic [2:0] S_R     = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [63:0] r_inst64;
    logic        r_err;
    logic        r_kill;

    logic        w_rerr;
    logic [31:0] w_word;

    assign w_rerr = (rresp_i != 2'b00);
    assign w_word = r_pc[2] ? rdata_i[63:32] : rdata_i[31:0];

    assign pc_ready_o   = (r_state == S_IDLE);
    assign arvalid_o    = (r_state == S_AR);
    assign araddr_o     = {r_pc[31:3], 3'b000};
    assign rready_o     = (r_state == S_R) || (r_state == S_DRAIN);
    assign inst_valid_o = (r_state == S_OUT);
    assign inst_pc_o    = r_pc;
    assign inst_o       = r_inst;
    assign inst64_o     = r_inst64;
    assign inst_err_o   = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_inst   <= '0;
            r_inst64 <= '0;
            r_err    <= 1'b0;
            r_kill   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_kill <= 1'b0;
                    if (pc_valid_i && !flush_i) begin
                        r_pc <= pc_i;
                        if (pc_i[1:0] == 2'b00) begin
                            r_state <= S_AR;
                        end else begin
                            // misaligned PC never touches the bus
                            r_err    <= 1'b1;
                            r_inst   <= NOP_INST;
                            r_inst64 <= '0;
                            r_state  <= S_OUT;
                        end
                    end
                end
                S_AR: begin
                    // the address phase must complete; a flush only marks the beat for draining
                    if (flush_i) r_kill <= 1'b1;
                    if (arready_i) r_state <= (r_kill || flush_i) ? S_DRAIN : S_R;
                end
                S_R: begin
                    if (rvalid_i) begin
                        if (flush_i) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_err    <= w_rerr;
                            r_inst   <= w_rerr ? NOP_INST : w_word;
                            r_inst64 <= w_rerr ? 64'd0 : rdata_i;
                            r_state  <= S_OUT;
                        end
                    end else if (flush_i) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (rvalid_i) r_state <= S_IDLE;
                end
                S_OUT: begin
                    if (inst_ready_i || flush_i) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    a_addr_align: assert property (@(posedge clk) disable iff (rst) araddr_o[2:0] == 3'b000);
    a_no_ar_in_r: assert property (@(posedge clk) disable iff (rst)
        ((r_state == S_R) || (r_state == S_DRAIN)) |-> !arvalid_o);
    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (inst_valid_o && !inst_ready_i && !flush_i) |=>
        (inst_valid_o && $stable(inst_pc_o) && $stable(inst_o) && $stable(inst64_o) && $stable(inst_err_o)));
endmodule

// File: tb/tb_ysyx_22050133_ifetch_bus.sv
// Directed bench for the fetch bridge with a small AR/R memory model that has programmable
// address and data wait states.
module tb_ysyx_22050133_ifetch_bus;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_valid_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        pc_ready_o;
    logic        flush_i = 1'b0;
    logic        arvalid_o;
    logic [31:0] araddr_o;
    logic        arready_i;
    logic        rvalid_i;
    logic [63:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rready_o;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_pc_o;
    logic [31:0] inst_o;
    logic [63:0] inst64_o;
    logic        inst_err_o;

    ysyx_22050133_ifetch_bus dut (
        .clk(clk), .rst(rst),
        .pc_valid_i(pc_valid_i), .pc_i(pc_i), .pc_ready_o(pc_ready_o), .flush_i(flush_i),
        .arvalid_o(arvalid_o), .araddr_o(araddr_o), .arready_i(arready_i),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rready_o(rready_o),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_pc_o(inst_pc_o),
        .inst_o(inst_o), .inst64_o(inst64_o), .inst_err_o(inst_err_o)
    );

    always #5 clk = ~clk;

    // memory model
    int          ar_dly = 0;
    int          r_dly  = 0;
    logic [1:0]  resp   = 2'b00;
    int          ar_cnt, r_cnt;
    logic        r_pend;
    logic [31:0] r_addr;

    function automatic logic [63:0] mem(input logic [31:0] a);
        case (a)
            32'h80000000: mem = 64'h00100093_00000513;
            32'h80000010: mem = 64'h12345678_9abcdef0;
            default:      mem = {a, ~a};
        endcase
    endfunction

    assign arready_i = arvalid_o && (ar_cnt == ar_dly);
    assign rvalid_i  = r_pend && (r_cnt == r_dly);
    assign rdata_i   = mem(r_addr);
    assign rresp_i   = resp;

    always @(posedge clk) begin
        if (rst) begin
            ar_cnt <= 0; r_cnt <= 0; r_pend <= 1'b0; r_addr <= '0;
        end else begin
            if (arvalid_o && arready_i) ar_cnt <= 0;
            else if (arvalid_o)         ar_cnt <= ar_cnt + 1;
            if (arvalid_o && arready_i) begin
                r_pend <= 1'b1; r_cnt <= 0; r_addr <= araddr_o;
            end else if (rvalid_i && rready_o) begin
                r_pend <= 1'b0;
            end else if (r_pend && !rvalid_i) begin
                r_cnt <= r_cnt + 1;
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic req(input logic [31:0] pc);
        pc_valid_i = 1'b1; pc_i = pc;
        tick;
        pc_valid_i = 1'b0;
    endtask

    task automatic take;
        inst_ready_i = 1'b1;
        tick;
        inst_ready_i = 1'b0;
    endtask

    initial begin
        int  ar_cyc;
        bit  ok, seen;
        logic [31:0] s_inst, s_pc;
        logic [63:0] s_64;

        tick; tick;
        rst = 1'b0;
        chk("rst_pc_ready", pc_ready_o, 1);
        chk("rst_arvalid", arvalid_o, 0);
        chk("rst_rready", rready_o, 0);
        chk("rst_inst_valid", inst_valid_o, 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_inst64", inst64_o, 0);
        chk("rst_err", inst_err_o, 0);
        chk("rst_araddr", araddr_o, 0);

        // 1: zero-wait fetch, latency t+3
        req(32'h80000000);
        chk("t1_arvalid", arvalid_o, 1);
        chk("t1_araddr", araddr_o, 32'h80000000);
        chk("t1_pc_ready", pc_ready_o, 0);
        tick;
        chk("t1_rready", rready_o, 1);
        chk("t1_early_valid", inst_valid_o, 0);
        tick;
        chk("t1_valid", inst_valid_o, 1);
        chk("t1_inst", inst_o, 32'h00000513);
        chk("t1_pc", inst_pc_o, 32'h80000000);
        chk("t1_inst64", inst64_o, 64'h00100093_00000513);
        chk("t1_err", inst_err_o, 0);
        chk("t1_no_bypass", pc_ready_o, 0);
        take;
        chk("t1_drop", inst_valid_o, 0);
        chk("t1_idle", pc_ready_o, 1);

        // 2: wait states, address held stable
        ar_dly = 3; r_dly = 2;
        req(32'h80000004);
        ar_cyc = 0; ok = 1'b1;
        for (int i = 0; i < 30 && !inst_valid_o; i++) begin
            if (arvalid_o) begin
                ar_cyc++;
                if (araddr_o != 32'h80000000) ok = 1'b0;
            end
            tick;
        end
        chk("t2_valid", inst_valid_o, 1);
        chk("t2_ar_cycles", ar_cyc, 4);
        chk("t2_addr_stable", ok, 1);
        chk("t2_inst", inst_o, 32'h00100093);
        chk("t2_pc", inst_pc_o, 32'h80000004);
        take;

        // 3: flush during AR, beat drained
        ar_dly = 2; r_dly = 1;
        req(32'h80000008);
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        chk("t3_ar_held", arvalid_o, 1);
        seen = 1'b0; ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (inst_valid_o) seen = 1'b1;
            if (rvalid_i && rready_o) begin
                tick;
                ok = 1'b1;
                break;
            end
            tick;
        end
        chk("t3_drained", ok, 1);
        chk("t3_ready_after", pc_ready_o, 1);
        chk("t3_no_valid", seen | inst_valid_o, 0);

        // 4: rvalid and flush in the same cycle, then a clean fetch
        ar_dly = 0; r_dly = 0;
        req(32'h80000008);
        tick;
        chk("t4_beat", rvalid_i & rready_o, 1);
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        chk("t4_no_valid", inst_valid_o, 0);
        chk("t4_idle", pc_ready_o, 1);
        req(32'h80000010);
        tick; tick;
        chk("t4_valid", inst_valid_o, 1);
        chk("t4_inst", inst_o, 32'h9abcdef0);
        chk("t4_pc", inst_pc_o, 32'h80000010);
        take;

        // 5: bus error, then misaligned PC
        resp = 2'b10;
        req(32'h80000000);
        tick; tick;
        resp = 2'b00;
        chk("t5_valid", inst_valid_o, 1);
        chk("t5_err", inst_err_o, 1);
        chk("t5_nop", inst_o, 32'h00000013);
        chk("t5_inst64", inst64_o, 0);
        take;
        req(32'h80000002);
        chk("t5m_valid", inst_valid_o, 1);
        chk("t5m_no_ar", arvalid_o, 0);
        chk("t5m_err", inst_err_o, 1);
        chk("t5m_nop", inst_o, 32'h00000013);
        chk("t5m_pc", inst_pc_o, 32'h80000002);
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        chk("t5m_flush_out", inst_valid_o, 0);
        chk("t5m_flush_idle", pc_ready_o, 1);

        // 6: backpressure in OUT, then reset while in R
        req(32'h80000004);
        tick; tick;
        s_inst = inst_o; s_pc = inst_pc_o; s_64 = inst64_o;
        ok = inst_valid_o;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (!inst_valid_o || inst_o != s_inst || inst_pc_o != s_pc || inst64_o != s_64) ok = 1'b0;
        end
        chk("t6_stable", ok, 1);
        chk("t6_inst", inst_o, 32'h00100093);
        take;
        r_dly = 3;
        req(32'h80000000);
        tick;
        chk("t6_in_r", rready_o, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t6_rst_ready", pc_ready_o, 1);
        chk("t6_rst_arvalid", arvalid_o, 0);
        chk("t6_rst_rready", rready_o, 0);
        r_dly = 0;
        req(32'h80000000);
        tick; tick;
        chk("t6_recover_valid", inst_valid_o, 1);
        chk("t6_recover_inst", inst_o, 32'h00000513);
        take;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
